nand_function_identifier: RTL and testbench

Sequential probe that identifies which operation a combinational 2-input, 3-bit-select logic unit (codes 0–7: NAND, AND, OR, NOR, XOR, XNOR, NOT a, NOT a) is currently performing. It drives all four input vectors into the unit, waits a settle time for the multi-level NAND network, samples the single-bit result, and decodes the 4-bit truth table back to a select code. It sits on the stimulus side of the logic unit as its self-check and recovery block.

---
 rtl/nand_function_identifier.sv | 103 ++++++++++
 tb/tb_nand_function_identifier.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/nand_function_identifier.sv
// Probes a 2-input logic unit with all four operand vectors and decodes the
// captured truth table back to the unit's select code.
module nand_function_identifier #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       probe_a,
    output logic       probe_b,
    input  logic       probe_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic [2:0] sel_id,
    output logic       match,
    output logic       ambiguous
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PROBE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    logic [1:0] state;
    logic [1:0] k;
    logic [3:0] cnt;
    logic       last_cycle;
    logic [3:0] final_table;
    logic [2:0] dec_sel;
    logic       dec_match;
    logic       dec_amb;

    assign last_cycle = (cnt == SETTLE_L);

    // Decode sees the table as it will be once the final vector lands.
    always_comb begin
        final_table    = truth_table;
        final_table[3] = probe_out;
        dec_sel        = 3'd0;
        dec_match      = 1'b1;
        dec_amb        = 1'b0;
        case (final_table)
            4'b0111: dec_sel = 3'd0;
            4'b1000: dec_sel = 3'd1;
            4'b1110: dec_sel = 3'd2;
            4'b0001: dec_sel = 3'd3;
            4'b0110: dec_sel = 3'd4;
            4'b1001: dec_sel = 3'd5;
            4'b0011: begin
                dec_sel = 3'd6;
                dec_amb = 1'b1;
            end
            default: dec_match = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            cnt         <= '0;
            truth_table <= '0;
            sel_id      <= '0;
            match       <= 1'b0;
            ambiguous   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= PROBE;
                        k     <= '0;
                        cnt   <= '0;
                    end
                end
                PROBE: begin
                    if (last_cycle) begin
                        truth_table[k] <= probe_out;
                        cnt            <= '0;
                        k              <= k + 2'd1;
                        if (k == 2'd3) begin
                            state     <= DONE;
                            sel_id    <= dec_sel;
                            match     <= dec_match;
                            ambiguous <= dec_amb;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == PROBE);
    assign done    = (state == DONE);
    assign probe_a = busy & k[1];
    assign probe_b = busy & k[0];

endmodule

// File: tb/tb_nand_function_identifier.sv
// Directed bench: behavioural logic unit feeding the probe, table-driven
// vectors plus hand sequences for reset, start filtering and SETTLE=0.
module tb_nand_function_identifier;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       probe_a, probe_b, probe_out;
    logic       busy, done, match, ambiguous;
    logic [3:0] truth_table;
    logic [2:0] sel_id;

    logic       start0;
    logic       probe_a0, probe_b0, probe_out0;
    logic       busy0, done0, match0, ambiguous0;
    logic [3:0] truth_table0;
    logic [2:0] sel_id0;

    logic [2:0] sel_r;
    logic [1:0] mode;
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nand_function_identifier #(.SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .probe_a(probe_a), .probe_b(probe_b), .probe_out(probe_out),
        .busy(busy), .done(done), .truth_table(truth_table),
        .sel_id(sel_id), .match(match), .ambiguous(ambiguous)
    );

    nand_function_identifier #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .probe_a(probe_a0), .probe_b(probe_b0), .probe_out(probe_out0),
        .busy(busy0), .done(done0), .truth_table(truth_table0),
        .sel_id(sel_id0), .match(match0), .ambiguous(ambiguous0)
    );

    // Behavioural logic unit; mode 1/2 tie the result low/high.
    always_comb begin
        probe_out = 1'b1;
        case (mode)
            2'd0: begin
                case (sel_r)
                    3'd0: probe_out = ~(probe_a & probe_b);
                    3'd1: probe_out = probe_a & probe_b;
                    3'd2: probe_out = probe_a | probe_b;
                    3'd3: probe_out = ~(probe_a | probe_b);
                    3'd4: probe_out = probe_a ^ probe_b;
                    3'd5: probe_out = ~(probe_a ^ probe_b);
                    default: probe_out = ~probe_a;
                endcase
            end
            2'd1:    probe_out = 1'b0;
            default: probe_out = 1'b1;
        endcase
    end
    assign probe_out0 = probe_a0 ^ probe_b0;

    typedef struct {
        logic [2:0] sel;
        logic [1:0] mode;
        logic [3:0] tt;
        logic [2:0] id;
        logic       m;
        logic       amb;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] all_outs();
        return {2'b00, probe_a, probe_b, busy, done, truth_table, sel_id, match, ambiguous};
    endfunction

    // One full run with cycle-by-cycle probe checks; disturb pulses start mid-run and in DONE.
    task automatic run_vec(input int idx, input bit disturb);
        sel_r = vecs[idx].sel;
        mode  = vecs[idx].mode;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            check($sformatf("v%0d seq c%0d", idx, c),
                  {12'd0, busy, done, probe_a, probe_b}, {12'd0, 2'b10, 2'(c / 3)});
            start = disturb && (c == 5);
            @(negedge clk);
        end
        check($sformatf("v%0d done", idx), {12'd0, busy, done, probe_a, probe_b}, 16'h0004);
        check($sformatf("v%0d table", idx), {12'd0, truth_table}, {12'd0, vecs[idx].tt});
        check($sformatf("v%0d id", idx), {11'd0, sel_id, match, ambiguous},
              {11'd0, vecs[idx].id, vecs[idx].m, vecs[idx].amb});
        start = disturb;
        @(negedge clk) start = 1'b0;
        check($sformatf("v%0d after", idx), {12'd0, busy, done, probe_a, probe_b}, 16'h0000);
        @(negedge clk);
        check($sformatf("v%0d idle", idx), {12'd0, busy, done, probe_a, probe_b}, 16'h0000);
    endtask

    initial begin
        int   t_done[$];
        logic saw_done;

        vecs[0] = '{3'd0, 2'd0, 4'b0111, 3'd0, 1'b1, 1'b0};
        vecs[1] = '{3'd1, 2'd0, 4'b1000, 3'd1, 1'b1, 1'b0};
        vecs[2] = '{3'd2, 2'd0, 4'b1110, 3'd2, 1'b1, 1'b0};
        vecs[3] = '{3'd3, 2'd0, 4'b0001, 3'd3, 1'b1, 1'b0};
        vecs[4] = '{3'd4, 2'd0, 4'b0110, 3'd4, 1'b1, 1'b0};
        vecs[5] = '{3'd5, 2'd0, 4'b1001, 3'd5, 1'b1, 1'b0};
        vecs[6] = '{3'd6, 2'd0, 4'b0011, 3'd6, 1'b1, 1'b1};
        vecs[7] = '{3'd7, 2'd0, 4'b0011, 3'd6, 1'b1, 1'b1};
        vecs[8] = '{3'd0, 2'd1, 4'b0000, 3'd0, 1'b0, 1'b0};
        vecs[9] = '{3'd0, 2'd2, 4'b1111, 3'd0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; start0 = 1'b0; sel_r = '0; mode = '0;
        repeat (2) @(negedge clk);
        check("reset outs", all_outs(), 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check("idle outs", all_outs(), 16'h0000);

        for (int i = 0; i < 10; i++) run_vec(i, 1'b0);

        // Reset during vector 2, then a clean rerun.
        sel_r = 3'd2; mode = 2'd0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre-rst vec2", {12'd0, busy, done, probe_a, probe_b}, 16'h000A);
        #1 rst = 1'b1;
        #1 check("rst mid-run", all_outs(), 16'h0000);
        @(negedge clk) rst = 1'b0;
        saw_done = 1'b0;
        repeat (20) @(negedge clk) saw_done |= done | busy;
        check("no done after rst", {15'd0, saw_done}, 16'h0000);
        run_vec(2, 1'b0);

        run_vec(4, 1'b1);

        // Start held high: periodic runs with stable results.
        sel_r = 3'd5; mode = 2'd0;
        @(negedge clk) start = 1'b1;
        for (int c = 0; c < 60 && t_done.size() < 3; c++) begin
            @(negedge clk);
            if (done) begin
                t_done.push_back(cyc);
                check("held result", {8'd0, truth_table, sel_id, match}, {8'd0, 4'b1001, 3'd5, 1'b1});
            end
        end
        start = 1'b0;
        check("held pulses", 16'(t_done.size()), 16'd3);
        if (t_done.size() == 3) begin
            check("held period1", 16'(t_done[1] - t_done[0]), 16'd14);
            check("held period2", 16'(t_done[2] - t_done[1]), 16'd14);
        end
        repeat (3) @(negedge clk);

        // SETTLE=0 instance with XOR unit.
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("s0 seq c%0d", c), {12'd0, busy0, done0, probe_a0, probe_b0},
                  {12'd0, 2'b10, 2'(c)});
            @(negedge clk);
        end
        check("s0 done", {12'd0, busy0, done0, probe_a0, probe_b0}, 16'h0004);
        check("s0 result", {7'd0, truth_table0, sel_id0, match0, ambiguous0},
              {7'd0, 4'b0110, 3'd4, 1'b1, 1'b0});
        @(negedge clk);
        check("s0 after", {14'd0, busy0, done0}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
